// File: rtl/ads1115_target_pkg.sv
// Shared definitions for the ADS1115 I2C target emulator: pointer codes, register reset values, FSM states.
package ads1115_target_pkg;

  localparam logic [1:0] PTR_CONV = 2'd0;
  localparam logic [1:0] PTR_CFG  = 2'd1;
  localparam logic [1:0] PTR_LO   = 2'd2;
  localparam logic [1:0] PTR_HI   = 2'd3;

  localparam logic [15:0] CFG_RST = 16'h8583;
  localparam logic [15:0] LO_RST  = 16'h8000;
  localparam logic [15:0] HI_RST  = 16'h7FFF;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_PTR, S_PTR_ACK, S_WR_MSB, S_MSB_ACK,
    S_WR_LSB, S_LSB_ACK, S_RD_MSB, S_RD_LSB, S_RD_MACK, S_IGNORE
  } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronisers with edge, START and STOP strobes derived from the synchronised levels.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic sda_s,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  logic [SYNC_STAGES-1:0] scl_ff, sda_ff;
  logic                   scl_q, sda_q;
  logic                   scl_s;

  // Released bus (both lines high) is the reset level so no spurious edges after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_ff <= '1;
      sda_ff <= '1;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[SYNC_STAGES-2:0], i_scl};
      sda_ff <= {sda_ff[SYNC_STAGES-2:0], i_sda};
      scl_q  <= scl_ff[SYNC_STAGES-1];
      sda_q  <= sda_ff[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_ff[SYNC_STAGES-1];
  assign sda_s      = sda_ff[SYNC_STAGES-1];
  assign scl_rise_c = scl_s & ~scl_q;
  assign scl_fall_c = ~scl_s & scl_q;
  assign start_c    = scl_s & scl_q & ~sda_s & sda_q;
  assign stop_c     = scl_s & scl_q & sda_s & ~sda_q;

endmodule

// File: rtl/ads1115_target.sv
// ADS1115 register-map I2C target. Optional ALERT/RDY pulse under macro ADS1115_TARGET_ALERT_EN.
module ads1115_target
  import ads1115_target_pkg::*;
#(
  parameter logic [6:0]  ADDR        = 7'h48,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ALERT_PULSE = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_scl,
  input  logic        i_sda,
  output logic        o_sda,
  input  logic [15:0] i_conv_data,
  input  logic        i_conv_valid,
  output logic [15:0] o_config,
  output logic        o_conv_start,
  output logic        o_alert
);

  logic sda_s, scl_rise_c, scl_fall_c, start_c, stop_c;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_scl      (i_scl),
    .i_sda      (i_sda),
    .sda_s      (sda_s),
    .scl_rise_c (scl_rise_c),
    .scl_fall_c (scl_fall_c),
    .start_c    (start_c),
    .stop_c     (stop_c)
  );

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [7:0]  shreg, shreg_nxt, msb, msb_nxt;
  logic        rw, rw_nxt, sda_r, sda_nxt, conv_start_r, conv_start_nxt;
  logic [1:0]  ptr, ptr_nxt;
  logic [15:0] conv, conv_nxt, cfg, cfg_nxt, lo, lo_nxt, hi, hi_nxt, snap, snap_nxt;
  logic [15:0] reg_sel, wr_val;

  always_comb begin
    reg_sel = conv;
    case (ptr)
      PTR_CFG: reg_sel = cfg;
      PTR_LO:  reg_sel = lo;
      PTR_HI:  reg_sel = hi;
      default: reg_sel = conv;
    endcase
  end

  assign wr_val = {msb, shreg[6:0], sda_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      shreg        <= 8'd0;
      msb          <= 8'd0;
      rw           <= 1'b0;
      ptr          <= PTR_CONV;
      conv         <= 16'h0000;
      cfg          <= CFG_RST;
      lo           <= LO_RST;
      hi           <= HI_RST;
      snap         <= 16'h0000;
      sda_r        <= 1'b1;
      conv_start_r <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      shreg        <= shreg_nxt;
      msb          <= msb_nxt;
      rw           <= rw_nxt;
      ptr          <= ptr_nxt;
      conv         <= conv_nxt;
      cfg          <= cfg_nxt;
      lo           <= lo_nxt;
      hi           <= hi_nxt;
      snap         <= snap_nxt;
      sda_r        <= sda_nxt;
      conv_start_r <= conv_start_nxt;
    end
  end

  // Bits shift in on SCL rise; SDA drive changes only on SCL fall
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    shreg_nxt      = shreg;
    msb_nxt        = msb;
    rw_nxt         = rw;
    ptr_nxt        = ptr;
    conv_nxt       = conv;
    cfg_nxt        = cfg;
    lo_nxt         = lo;
    hi_nxt         = hi;
    snap_nxt       = snap;
    sda_nxt        = sda_r;
    conv_start_nxt = 1'b0;

    if (i_conv_valid) conv_nxt = i_conv_data;

    if (stop_c) begin
      state_nxt = S_IDLE;
      sda_nxt   = 1'b1;
    end else if (start_c) begin
      state_nxt = S_ADDR;
      cnt_nxt   = 4'd0;
      sda_nxt   = 1'b1;
    end else begin
      case (state)
        S_ADDR, S_WR_PTR, S_WR_MSB, S_WR_LSB: begin
          if (scl_rise_c) begin
            shreg_nxt = {shreg[6:0], sda_s};
            cnt_nxt   = cnt + 4'd1;
            if (state == S_WR_LSB && cnt == 4'd7) begin
              case (ptr)
                PTR_CFG: begin
                  cfg_nxt        = wr_val;
                  conv_start_nxt = wr_val[15];
                end
                PTR_LO:  lo_nxt = wr_val;
                PTR_HI:  hi_nxt = wr_val;
                default: ;
              endcase
            end
          end else if (scl_fall_c && cnt == 4'd8) begin
            sda_nxt = 1'b0;
            case (state)
              S_ADDR: begin
                if (shreg[7:1] == ADDR) begin
                  state_nxt = S_ADDR_ACK;
                  rw_nxt    = shreg[0];
                end else begin
                  state_nxt = S_IGNORE;
                  sda_nxt   = 1'b1;
                end
              end
              S_WR_PTR: begin
                ptr_nxt   = shreg[1:0];
                state_nxt = S_PTR_ACK;
              end
              S_WR_MSB: begin
                msb_nxt   = shreg;
                state_nxt = S_MSB_ACK;
              end
              default: state_nxt = S_LSB_ACK;
            endcase
          end
        end
        S_ADDR_ACK: begin
          if (scl_rise_c && rw) begin
            snap_nxt = reg_sel;
          end else if (scl_fall_c) begin
            cnt_nxt   = 4'd0;
            state_nxt = rw ? S_RD_MSB : S_WR_PTR;
            sda_nxt   = rw ? snap[15] : 1'b1;
          end
        end
        S_PTR_ACK, S_LSB_ACK: begin
          if (scl_fall_c) begin
            state_nxt = S_WR_MSB;
            cnt_nxt   = 4'd0;
            sda_nxt   = 1'b1;
          end
        end
        S_MSB_ACK: begin
          if (scl_fall_c) begin
            state_nxt = S_WR_LSB;
            cnt_nxt   = 4'd0;
            sda_nxt   = 1'b1;
          end
        end
        // Ninth bit after the MSB is the master's ack slot; SDA stays released
        S_RD_MSB: begin
          if (scl_rise_c) begin
            cnt_nxt = cnt + 4'd1;
          end else if (scl_fall_c) begin
            if (cnt == 4'd9) begin
              state_nxt = S_RD_LSB;
              cnt_nxt   = 4'd0;
              sda_nxt   = snap[7];
            end else if (cnt == 4'd8) begin
              sda_nxt = 1'b1;
            end else begin
              sda_nxt = snap[4'd15 - cnt];
            end
          end
        end
        S_RD_LSB: begin
          if (scl_rise_c) begin
            cnt_nxt = cnt + 4'd1;
          end else if (scl_fall_c) begin
            if (cnt == 4'd8) begin
              state_nxt = S_RD_MACK;
              cnt_nxt   = 4'd0;
              sda_nxt   = 1'b1;
            end else begin
              sda_nxt = snap[4'd7 - cnt];
            end
          end
        end
        S_RD_MACK: begin
          if (scl_rise_c) begin
            if (sda_s) state_nxt = S_IGNORE;
            else       snap_nxt  = reg_sel;
          end else if (scl_fall_c) begin
            state_nxt = S_RD_MSB;
            cnt_nxt   = 4'd0;
            sda_nxt   = snap[15];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_sda        = sda_r;
  assign o_config     = cfg;
  assign o_conv_start = conv_start_r;

`ifdef ADS1115_TARGET_ALERT_EN
  localparam int unsigned AW = $clog2(ALERT_PULSE + 1);
  logic [AW-1:0] alert_cnt;
  logic          alert_r;

  // RDY mode is hi[15]=1, lo[15]=0; a new strobe reloads the width
  always_ff @(posedge clk) begin
    if (rst) begin
      alert_cnt <= '0;
      alert_r   <= 1'b1;
    end else if (i_conv_valid && hi[15] && !lo[15]) begin
      alert_cnt <= AW'(ALERT_PULSE);
      alert_r   <= 1'b0;
    end else if (alert_cnt != '0) begin
      alert_cnt <= alert_cnt - AW'(1);
      alert_r   <= (alert_cnt == AW'(1));
    end else begin
      alert_r   <= 1'b1;
    end
  end

  assign o_alert = alert_r;
`else
  assign o_alert = 1'b1 | ALERT_PULSE[0];
`endif

endmodule

// File: tb/tb_ads1115_target.sv
// Directed bench for ads1115_target: bit-banged I2C master on an open-drain SDA model.
module tb_ads1115_target;
  import ads1115_target_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        scl_m, sda_m;
  logic        o_sda, o_conv_start, o_alert;
  logic        conv_valid;
  logic [15:0] conv_data, o_config;
  logic        sda_bus;

  assign sda_bus = sda_m & o_sda;

  ads1115_target dut (
    .clk          (clk),
    .rst          (rst),
    .i_scl        (scl_m),
    .i_sda        (sda_bus),
    .o_sda        (o_sda),
    .i_conv_data  (conv_data),
    .i_conv_valid (conv_valid),
    .o_config     (o_config),
    .o_conv_start (o_conv_start),
    .o_alert      (o_alert)
  );

  always #5 clk = ~clk;

  int   checks = 0, failures = 0;
  int   start_pulses = 0, drv_cycles = 0, alert_low = 0;
  logic watch = 1'b0, count_alert = 1'b0;

  always @(negedge clk) begin
    if (o_conv_start) start_pulses++;
    if (watch && !o_sda) drv_cycles++;
    if (count_alert && !o_alert) alert_low++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; half();
    scl_m = 1'b1; half();
    sda_m = 1'b0; half();
    scl_m = 1'b0; half();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; half();
    scl_m = 1'b1; half();
    sda_m = 1'b1; half();
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b;    half();
    scl_m = 1'b1; half();
    s     = sda_bus;
    scl_m = 1'b0; half();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], d);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(1'b1, d[i]);
    clk_bit(mack, s);
  endtask

  task automatic pulse_conv(input logic [15:0] d);
    @(negedge clk);
    conv_data  = d;
    conv_valid = 1'b1;
    @(negedge clk);
    conv_valid = 1'b0;
  endtask

  logic       ack, b;
  logic [7:0] d0, d1;

  initial begin
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; conv_valid = 1'b0; conv_data = 16'h0000;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sda", 32'(o_sda), 32'h1);
    chk("rst_cfg", 32'(o_config), 32'h8583);
    chk("rst_start", 32'(o_conv_start), 32'h0);
    chk("rst_alert", 32'(o_alert), 32'h1);

    // config write 0x8483
    i2c_start();
    write_byte(8'h90, ack); chk("cfg_addr_ack", 32'(ack), 32'h0);
    write_byte(8'h01, ack); chk("cfg_ptr_ack", 32'(ack), 32'h0);
    write_byte(8'h84, ack); chk("cfg_msb_ack", 32'(ack), 32'h0);
    write_byte(8'h83, ack); chk("cfg_lsb_ack", 32'(ack), 32'h0);
    i2c_stop();
    chk("cfg_value", 32'(o_config), 32'h8483);
    chk("cfg_start_pulses", 32'(start_pulses), 32'd1);

    // conversion read through repeated START
    pulse_conv(16'h1234);
    i2c_start();
    write_byte(8'h90, ack); chk("rd_waddr_ack", 32'(ack), 32'h0);
    write_byte(8'h00, ack); chk("rd_ptr_ack", 32'(ack), 32'h0);
    i2c_start();
    write_byte(8'h91, ack); chk("rd_raddr_ack", 32'(ack), 32'h0);
    read_byte(1'b0, d0); chk("rd_msb", 32'(d0), 32'h12);
    read_byte(1'b1, d1); chk("rd_lsb", 32'(d1), 32'h34);
    i2c_stop();

    // new conversion lands between MSB and LSB of a read
    i2c_start();
    write_byte(8'h91, ack); chk("tear_addr_ack", 32'(ack), 32'h0);
    read_byte(1'b0, d0);
    pulse_conv(16'hABCD);
    read_byte(1'b1, d1);
    i2c_stop();
    chk("tear_msb", 32'(d0), 32'h12);
    chk("tear_lsb", 32'(d1), 32'h34);
    i2c_start();
    write_byte(8'h91, ack); chk("tear2_addr_ack", 32'(ack), 32'h0);
    read_byte(1'b0, d0); chk("tear2_msb", 32'(d0), 32'hAB);
    read_byte(1'b1, d1); chk("tear2_lsb", 32'(d1), 32'hCD);
    i2c_stop();

    // wrong address: never drives SDA, sits in IGNORE until STOP
    i2c_start();
    watch = 1'b1;
    write_byte(8'h92, ack); chk("wrong_addr_nack", 32'(ack), 32'h1);
    write_byte(8'h01, ack); chk("wrong_ptr_nack", 32'(ack), 32'h1);
    write_byte(8'h00, ack);
    chk("wrong_state_ignore", 32'(dut.state), 32'(S_IGNORE));
    i2c_stop();
    watch = 1'b0;
    chk("wrong_sda_driven", 32'(drv_cycles), 32'd0);
    chk("wrong_state_idle", 32'(dut.state), 32'(S_IDLE));
    chk("wrong_cfg_kept", 32'(o_config), 32'h8483);

    // write to pointer 0 is acked but discarded
    i2c_start();
    write_byte(8'h90, ack); chk("p0_addr_ack", 32'(ack), 32'h0);
    write_byte(8'h00, ack); chk("p0_ptr_ack", 32'(ack), 32'h0);
    write_byte(8'hFF, ack); chk("p0_msb_ack", 32'(ack), 32'h0);
    write_byte(8'hFF, ack); chk("p0_lsb_ack", 32'(ack), 32'h0);
    i2c_stop();
    chk("p0_no_pulse", 32'(start_pulses), 32'd1);

    // reset in the middle of a read of 0xABCD
    i2c_start();
    write_byte(8'h91, ack); chk("mid_addr_ack", 32'(ack), 32'h0);
    clk_bit(1'b1, b);       chk("mid_bit15", 32'(b), 32'h1);
    chk("mid_bit14_driven", 32'(o_sda), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_sda", 32'(o_sda), 32'h1);
    chk("mid_rst_cfg", 32'(o_config), 32'h8583);
    rst = 1'b0;
    half();
    i2c_stop();

    // conversion and pointer both back at reset values
    i2c_start();
    write_byte(8'h91, ack); chk("post_addr_ack", 32'(ack), 32'h0);
    read_byte(1'b0, d0); chk("post_msb", 32'(d0), 32'h00);
    read_byte(1'b1, d1); chk("post_lsb", 32'(d1), 32'h00);
    i2c_stop();

    // RDY mode: hi=0x8000, lo=0x0000
    i2c_start();
    write_byte(8'h90, ack); write_byte(8'h03, ack);
    write_byte(8'h80, ack); write_byte(8'h00, ack); chk("hi_lsb_ack", 32'(ack), 32'h0);
    i2c_stop();
    i2c_start();
    write_byte(8'h90, ack); write_byte(8'h02, ack);
    write_byte(8'h00, ack); write_byte(8'h00, ack); chk("lo_lsb_ack", 32'(ack), 32'h0);
    i2c_stop();
    count_alert = 1'b1;
    pulse_conv(16'h0042);
    repeat (300) @(negedge clk);
    count_alert = 1'b0;
`ifdef ADS1115_TARGET_ALERT_EN
    chk("alert_low_cycles", 32'(alert_low), 32'd200);
`else
    chk("alert_low_cycles", 32'(alert_low), 32'd0);
`endif
    chk("alert_idle", 32'(o_alert), 32'h1);
    chk("final_start_pulses", 32'(start_pulses), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
